// File: rtl/arb_mux_reg.sv
// rtl/arb_mux_reg.sv - N-input registered selector with explicit-select or round-robin source choice
// One output register stage with valid/ready handshake, stall and synchronous flush.
module arb_mux_reg #(
  parameter int WIDTH  = 16,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2,
  parameter int MODE   = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        select,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SEL_W-1:0]        grant
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [SEL_W-1:0] grant_q, grant_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;

  logic             can_load;
  logic             src_ok;
  logic             xfer;
  logic [SEL_W-1:0] src;
  logic [WIDTH-1:0] src_data;

  assign can_load = ~flush & (~valid_q | out_ready);

  // Round-robin scan runs backwards so the last hit is the first candidate after ptr.
  always_comb begin
    src    = '0;
    src_ok = 1'b0;
    if (MODE == 0) begin
      src    = select;
      src_ok = (32'(select) < 32'(NUM_IN));
    end else begin
      for (int k = NUM_IN; k >= 1; k--) begin
        if (in_valid[(int'(ptr_q) + k) % NUM_IN]) begin
          src    = SEL_W'((int'(ptr_q) + k) % NUM_IN);
          src_ok = 1'b1;
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    xfer     = 1'b0;
    src_data = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (src_ok && (32'(src) == 32'(i))) begin
        in_ready[i] = can_load;
        xfer        = can_load & in_valid[i];
        src_data    = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (xfer) begin
      data_d  = src_data;
      valid_d = 1'b1;
      grant_d = src;
      if (MODE != 0) ptr_d = src;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      grant_q <= '0;
      ptr_q   <= SEL_W'(NUM_IN - 1);
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign grant     = grant_q;

endmodule

// File: tb/tb_arb_mux_reg.sv
// tb/tb_arb_mux_reg.sv - directed bench for arb_mux_reg in select and round-robin modes
// One instance per MODE shares clock, reset, data, flush and out_ready.
module tb_arb_mux_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] din [4];
  logic [63:0] in_data;
  logic [3:0]  iv0, iv1;
  logic [3:0]  rdy0, rdy1;
  logic [1:0]  sel;
  logic        flush, out_ready;
  logic [15:0] od0, od1;
  logic        ov0, ov1;
  logic [1:0]  gr0, gr1;

  int checks   = 0;
  int failures = 0;

  assign in_data = {din[3], din[2], din[1], din[0]};

  always #5 clk = ~clk;

  arb_mux_reg #(.WIDTH(16), .NUM_IN(4), .SEL_W(2), .MODE(0)) u0 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(iv0), .in_ready(rdy0),
    .select(sel), .flush(flush), .out_data(od0), .out_valid(ov0),
    .out_ready(out_ready), .grant(gr0)
  );

  arb_mux_reg #(.WIDTH(16), .NUM_IN(4), .SEL_W(2), .MODE(1)) u1 (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(iv1), .in_ready(rdy1),
    .select(2'd0), .flush(flush), .out_data(od1), .out_valid(ov1),
    .out_ready(out_ready), .grant(gr1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; iv0 = '0; iv1 = '0; sel = '0; flush = 1'b0; out_ready = 1'b0;
    din[0] = 16'h1111; din[1] = 16'h2222; din[2] = 16'h3333; din[3] = 16'h4444;
    #2;
    check("rst_valid0", 32'(ov0), 32'd0);
    check("rst_data0", 32'(od0), 32'd0);
    check("rst_grant0", 32'(gr0), 32'd0);
    check("rst_valid1", 32'(ov1), 32'd0);
    tick();
    reset = 1'b0;

    // explicit select of input 2
    sel = 2'd2; iv0 = 4'b0100; din[2] = 16'hBEEF; out_ready = 1'b1;
    #1 check("t1_ready", 32'(rdy0), 32'h4);
    tick();
    check("t1_data", 32'(od0), 32'hBEEF);
    check("t1_valid", 32'(ov0), 32'd1);
    check("t1_grant", 32'(gr0), 32'd2);

    // stall three cycles while input changes
    out_ready = 1'b0; din[2] = 16'h1234;
    #1 check("t2_ready_stall", 32'(rdy0), 32'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t2_hold_data", 32'(od0), 32'hBEEF);
      check("t2_hold_valid", 32'(ov0), 32'd1);
    end
    out_ready = 1'b1;
    #1 check("t2_ready_rel", 32'(rdy0), 32'h4);
    tick();
    check("t2_data", 32'(od0), 32'h1234);

    // drain: valid drops, data and grant hold
    iv0 = 4'b0000;
    tick();
    check("drain_valid", 32'(ov0), 32'd0);
    check("drain_data", 32'(od0), 32'h1234);
    check("drain_grant", 32'(gr0), 32'd2);

    // selected input not valid: ready offered but nothing loads
    sel = 2'd1; iv0 = 4'b0001;
    #1 check("nosrc_ready", 32'(rdy0), 32'h2);
    tick();
    check("nosrc_valid", 32'(ov0), 32'd0);
    iv0 = 4'b0000;

    // round robin, all requesting
    iv1 = 4'b1111;
    #1 check("t3_ready", 32'(rdy1), 32'h1);
    tick(); check("t3_g0", 32'(gr1), 32'd0); check("t3_d0", 32'(od1), 32'h1111);
    tick(); check("t3_g1", 32'(gr1), 32'd1);
    tick(); check("t3_g2", 32'(gr1), 32'd2);
    tick(); check("t3_g3", 32'(gr1), 32'd3);
    tick(); check("t3_g4", 32'(gr1), 32'd0);
    tick(); check("t4_ptr1", 32'(gr1), 32'd1);

    // ptr=1, requests on 0 and 3
    iv1 = 4'b1001;
    #1 check("t4_ready3", 32'(rdy1), 32'h8);
    tick(); check("t4_g3", 32'(gr1), 32'd3); check("t4_d3", 32'(od1), 32'h4444);
    tick(); check("t4_g0", 32'(gr1), 32'd0);
    out_ready = 1'b0;
    #1 check("t4_ready_stall", 32'(rdy1), 32'h0);
    tick(); tick();
    check("t4_stall_grant", 32'(gr1), 32'd0);
    check("t4_stall_valid", 32'(ov1), 32'd1);
    out_ready = 1'b1;
    #1 check("t4_ready_rel", 32'(rdy1), 32'h8);
    tick(); check("t4_rel_grant", 32'(gr1), 32'd3);

    // flush with valid output and pending requests
    flush = 1'b1;
    #1 check("t5_ready_flush", 32'(rdy1), 32'h0);
    tick();
    check("t5_valid", 32'(ov1), 32'd0);
    check("t5_grant_hold", 32'(gr1), 32'd3);
    check("t5_data_hold", 32'(od1), 32'h4444);
    flush = 1'b0;
    #1 check("t5_ready_ptr", 32'(rdy1), 32'h1);
    tick();
    check("t5_resume_grant", 32'(gr1), 32'd0);
    check("t5_resume_valid", 32'(ov1), 32'd1);

    // async reset between edges mid-stream
    iv1 = 4'b1111; sel = 2'd2; iv0 = 4'b0100;
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    check("t6_valid1", 32'(ov1), 32'd0);
    check("t6_data1", 32'(od1), 32'd0);
    check("t6_grant1", 32'(gr1), 32'd0);
    check("t6_valid0", 32'(ov0), 32'd0);
    check("t6_data0", 32'(od0), 32'd0);
    #1 reset = 1'b0;
    #1 check("t6_ready", 32'(rdy1), 32'h1);
    tick();
    check("t6_first_grant", 32'(gr1), 32'd0);
    check("t6_first_valid", 32'(ov1), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
